// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller and the seven-segment face decoder.
package dice_pkg;

    typedef enum logic [1:0] {IDLE, ROLL, SLOW, SHOW} state_e;

    localparam logic [2:0] FACE_BLANK = 3'd0;
    localparam logic [2:0] FACE_MIN   = 3'd1;
    localparam logic [2:0] FACE_MAX   = 3'd6;

    // Out-of-range codes also land on FACE_MIN so the counter can never stick on 0 or 7.
    function automatic logic [2:0] next_face(input logic [2:0] f);
        if (f >= FACE_MAX || f == FACE_BLANK) begin
            return FACE_MIN;
        end
        return f + 3'd1;
    endfunction

endpackage

// File: rtl/dice_face_ctr.sv
// Mod-6 face register: clear to blank, load to 1, or advance 1..6 with wrap.
module dice_face_ctr
    import dice_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       adv,
    output logic [2:0] face
);

    logic [2:0] face_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            face_q <= FACE_BLANK;
        end else if (clr) begin
            face_q <= FACE_BLANK;
        end else if (load) begin
            face_q <= FACE_MIN;
        end else if (adv) begin
            face_q <= next_face(face_q);
        end
    end

    assign face = face_q;

endmodule

// File: rtl/dice_roller.sv
// Roll controller: fast spin while held, decelerating settle on release, then hold the result.
module dice_roller
    import dice_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned SLOW_STEPS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    output logic [2:0] face,
    output logic       face_valid,
    output logic       rolling,
    output logic       done
);

    localparam int unsigned TW    = $clog2(TICK_DIV * (SLOW_STEPS + 1));
    localparam int unsigned StepW = (SLOW_STEPS < 2) ? 1 : $clog2(SLOW_STEPS + 1);

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [TW-1:0]      slow_limit;
    logic               rolling_q, valid_q, done_q;
    logic               face_clr, face_load, face_adv;

    dice_face_ctr u_face_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (face_clr),
        .load  (face_load),
        .adv   (face_adv),
        .face  (face)
    );

    // Deceleration interval for step k is TICK_DIV*(k+1) cycles.
    assign slow_limit = TW'(TICK_DIV * (32'(step_q) + 32'd1) - 32'd1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        step_d    = step_q;
        face_clr  = 1'b0;
        face_load = 1'b0;
        face_adv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (roll) begin
                    state_d   = ROLL;
                    face_load = 1'b1;
                    timer_d   = '0;
                end else begin
                    face_clr = 1'b1;
                end
            end
            ROLL: begin
                if (!roll) begin
                    state_d = SLOW;
                    step_d  = StepW'(1);
                    timer_d = '0;
                end else if (timer_q == TW'(TICK_DIV - 1)) begin
                    face_adv = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SLOW: begin
                // A new press abandons the settle without producing a result.
                if (roll) begin
                    state_d = ROLL;
                    timer_d = '0;
                    step_d  = '0;
                end else if (timer_q == slow_limit) begin
                    face_adv = 1'b1;
                    timer_d  = '0;
                    if (step_q == StepW'(SLOW_STEPS)) begin
                        state_d = SHOW;
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SHOW: begin
                if (roll) begin
                    state_d   = ROLL;
                    face_load = 1'b1;
                    timer_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            step_q    <= '0;
            rolling_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            rolling_q <= (state_d == ROLL) || (state_d == SLOW);
            valid_q   <= (state_d == SHOW);
            done_q    <= (state_d == SHOW) && (state_q != SHOW);
        end
    end

    assign rolling    = rolling_q;
    assign face_valid = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus queues hand-computed per-edge expectations,
// a negedge monitor pops and compares them.
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       roll = 1'b1;
    logic [2:0] face;
    logic       face_valid;
    logic       rolling;
    logic       done;

    typedef struct packed {
        int         at;
        logic [2:0] face;
        logic       valid;
        logic       rolling;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   edge_no = 0;
    int   base = 0;
    int   total = 0;
    int   bad = 0;

    dice_roller #(
        .TICK_DIV   (4),
        .SLOW_STEPS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .roll       (roll),
        .face       (face),
        .face_valid (face_valid),
        .rolling    (rolling),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at < edge_no) begin
            cur = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missed edge %0d: got no check, want face=%0d", cur.at, cur.face);
        end
        if (sb.size() > 0 && sb[0].at == edge_no) begin
            cur = sb.pop_front();
            total++;
            if ({face, face_valid, rolling, done} !==
                {cur.face, cur.valid, cur.rolling, cur.done}) begin
                bad++;
                $display("FAIL edge %0d: got face=%0d valid=%b rolling=%b done=%b, want face=%0d valid=%b rolling=%b done=%b",
                         cur.at, face, face_valid, rolling, done,
                         cur.face, cur.valid, cur.rolling, cur.done);
            end
        end
    end

    // Expect (face, valid, rolling, done) after scenario edges e0..e1 inclusive.
    task automatic expect_span(input int e0, input int e1, input logic [2:0] f,
                               input logic v, input logic r, input logic d);
        exp_t x;
        for (int k = e0; k <= e1; k++) begin
            x.at = base + k;
            x.face = f;
            x.valid = v;
            x.rolling = r;
            x.done = d;
            sb.push_back(x);
        end
    endtask

    // Return just after scenario edge e; inputs set afterwards are sampled at e+1.
    task automatic run_to(input int e);
        while (edge_no < base + e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_scenario();
        base = edge_no + 1;
    endtask

    initial begin
        // Reset held three edges with roll high.
        new_scenario();
        rst_n = 1'b0;
        roll  = 1'b1;
        expect_span(0, 3, 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(2);
        rst_n = 1'b1;
        roll  = 1'b0;
        run_to(3);

        // Spin then settle, then re-roll from SHOW, then reset during spin.
        new_scenario();
        roll = 1'b1;
        expect_span(0, 3, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(4, 7, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(8, 17, 3'd3, 1'b0, 1'b1, 1'b0);
        expect_span(18, 29, 3'd4, 1'b0, 1'b1, 1'b0);
        expect_span(30, 30, 3'd5, 1'b1, 1'b0, 1'b1);
        expect_span(31, 33, 3'd5, 1'b1, 1'b0, 1'b0);
        expect_span(34, 37, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(38, 38, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(39, 45, 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(9);
        roll = 1'b0;
        run_to(33);
        roll = 1'b1;
        run_to(38);
        rst_n = 1'b0;
        roll  = 1'b0;
        run_to(39);
        rst_n = 1'b1;
        run_to(45);

        // Wrap: hold long enough to pass 6 -> 1 -> 2.
        new_scenario();
        roll = 1'b1;
        expect_span(0, 3, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(4, 7, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(8, 11, 3'd3, 1'b0, 1'b1, 1'b0);
        expect_span(12, 15, 3'd4, 1'b0, 1'b1, 1'b0);
        expect_span(16, 19, 3'd5, 1'b0, 1'b1, 1'b0);
        expect_span(20, 23, 3'd6, 1'b0, 1'b1, 1'b0);
        expect_span(24, 27, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(28, 29, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(30, 33, 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(29);
        rst_n = 1'b0;
        roll  = 1'b0;
        run_to(30);
        rst_n = 1'b1;
        run_to(33);

        // Re-roll during SLOW, then a full settle from face 1.
        new_scenario();
        roll = 1'b1;
        expect_span(0, 3, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(4, 7, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(8, 17, 3'd3, 1'b0, 1'b1, 1'b0);
        expect_span(18, 21, 3'd4, 1'b0, 1'b1, 1'b0);
        expect_span(22, 25, 3'd5, 1'b0, 1'b1, 1'b0);
        expect_span(26, 29, 3'd6, 1'b0, 1'b1, 1'b0);
        expect_span(30, 38, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(39, 50, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(51, 51, 3'd3, 1'b1, 1'b0, 1'b1);
        expect_span(52, 53, 3'd3, 1'b1, 1'b0, 1'b0);
        expect_span(54, 55, 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(9);
        roll = 1'b0;
        run_to(13);
        roll = 1'b1;
        run_to(30);
        roll = 1'b0;
        run_to(53);
        rst_n = 1'b0;
        run_to(54);
        rst_n = 1'b1;
        run_to(55);

        // Reset mid-SLOW; no done afterwards without a new roll.
        new_scenario();
        roll = 1'b1;
        expect_span(0, 3, 3'd1, 1'b0, 1'b1, 1'b0);
        expect_span(4, 7, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_span(8, 17, 3'd3, 1'b0, 1'b1, 1'b0);
        expect_span(18, 19, 3'd4, 1'b0, 1'b1, 1'b0);
        expect_span(20, 40, 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(9);
        roll = 1'b0;
        run_to(19);
        rst_n = 1'b0;
        run_to(20);
        rst_n = 1'b1;
        run_to(40);

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
            total += sb.size();
            bad += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
